fp_mul_round: RTL

Post-multiply normalize/round stage of the floating-point multiplier. It consumes the result sign from the sign-XOR stage, the two biased exponents, and the 48-bit significand product (hidden bits included) from the significand multiplier. It produces a packed IEEE-754 single-precision result with status flags over a valid/ready handshake. It handles one transaction at a time with fixed latency; denormals are flushed to zero.

---
 rtl/fp_mul_round.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_round.sv
// Post-multiply normalize/round stage of the single-precision FP multiplier.
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_mul_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  exp1,
    input  logic [7:0]  exp2,
    input  logic        frac_nz1,
    input  logic        frac_nz2,
    input  logic [23:0] product_hi,
    input  logic [23:0] product_lo,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned E_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              sign_q,   sign_d;
    logic [EXP_W-1:0]  exp1_q,   exp1_d;
    logic [EXP_W-1:0]  exp2_q,   exp2_d;
    logic              fnz1_q,   fnz1_d;
    logic              fnz2_q,   fnz2_d;
    logic [PROD_W-1:0] prod_q,   prod_d;

    // The hidden bit is always 1 after normalization, so only the fraction is kept.
    logic [FRAC_W-1:0]     frac_q,   frac_d;
    logic                  guard_q,  guard_d;
    logic                  sticky_q, sticky_d;
    logic signed [E_W-1:0] exp_q,    exp_d;

    logic [31:0] result_q,    result_d;
    logic        ovf_q,       ovf_d;
    logic        unf_q,       unf_d;
    logic        inx_q,       inx_d;
    logic        out_valid_q, out_valid_d;

    logic signed [E_W-1:0] e_sum;
    logic                  round_up;
    logic [FRAC_W:0]       frac_sum;
    logic [FRAC_W-1:0]     frac_r;
    logic signed [E_W-1:0] exp_r;
    logic nan1, nan2, inf1, inf2, zero1, zero2;
    logic is_nan, is_inf, is_zero;

    assign e_sum = $signed(E_W'(exp1_q)) + $signed(E_W'(exp2_q)) - 10'sd127;

`ifdef FP_ROUND_NEAREST_EN
    assign round_up = guard_q && (sticky_q || frac_q[0]);
`else
    assign round_up = 1'b0;
`endif

    // A carry out of the fraction means the mantissa became 1.0 x 2: fraction is already zero.
    assign frac_sum = {1'b0, frac_q} + (FRAC_W + 1)'(round_up);
    assign frac_r   = frac_sum[FRAC_W-1:0];
    assign exp_r    = exp_q + $signed(E_W'(frac_sum[FRAC_W]));

    assign nan1    = (exp1_q == 8'hFF) && fnz1_q;
    assign nan2    = (exp2_q == 8'hFF) && fnz2_q;
    assign inf1    = (exp1_q == 8'hFF) && !fnz1_q;
    assign inf2    = (exp2_q == 8'hFF) && !fnz2_q;
    assign zero1   = (exp1_q == 8'h00);
    assign zero2   = (exp2_q == 8'h00);
    assign is_nan  = nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1);
    assign is_inf  = inf1 || inf2;
    assign is_zero = zero1 || zero2;

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp1_d      = exp1_q;
        exp2_d      = exp2_q;
        fnz1_d      = fnz1_q;
        fnz2_d      = fnz2_q;
        prod_d      = prod_q;
        frac_d      = frac_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        exp_d       = exp_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign_in;
                    exp1_d  = exp1;
                    exp2_d  = exp2;
                    fnz1_d  = frac_nz1;
                    fnz2_d  = frac_nz2;
                    prod_d  = {product_hi, product_lo};
                    state_d = NORM;
                end
            end
            NORM: begin
                if (prod_q[47]) begin
                    frac_d   = prod_q[46:24];
                    guard_d  = prod_q[23];
                    sticky_d = |prod_q[22:0];
                    exp_d    = e_sum + 10'sd1;
                end else begin
                    frac_d   = prod_q[45:23];
                    guard_d  = prod_q[22];
                    sticky_d = |prod_q[21:0];
                    exp_d    = e_sum;
                end
                state_d = ROUND;
            end
            ROUND: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                inx_d = 1'b0;
                if (is_nan) begin
                    result_d = 32'h7FC0_0000;
                end else if (is_inf) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (is_zero) begin
                    result_d = {sign_q, 31'd0};
                end else if (exp_r >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[7:0], frac_r};
                    inx_d    = guard_q || sticky_q;
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp1_q      <= '0;
            exp2_q      <= '0;
            fnz1_q      <= 1'b0;
            fnz2_q      <= 1'b0;
            prod_q      <= '0;
            frac_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            exp_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp1_q      <= exp1_d;
            exp2_q      <= exp2_d;
            fnz1_q      <= fnz1_d;
            fnz2_q      <= fnz2_d;
            prod_q      <= prod_d;
            frac_q      <= frac_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
